// File: rtl/mips_core_pkg.sv
// Shared core types: branch direction and the 2-bit saturating PHT counter state.
// pht_next gives one saturating training step of a counter toward the resolved outcome.
package mips_core_pkg;

  typedef enum logic {NOT_TAKEN = 1'b0, TAKEN = 1'b1} BranchOutcome;

  typedef enum logic [1:0] {STRONG_NT = 2'b00, WEAK_NT = 2'b01, WEAK_T = 2'b10, STRONG_T = 2'b11} PhtState;

  function automatic PhtState pht_next(PhtState s, BranchOutcome o);
    PhtState n;
    n = s;
    if (o == TAKEN) begin
      if (s != STRONG_T) n = PhtState'(s + 2'd1);
    end else begin
      if (s != STRONG_NT) n = PhtState'(s - 2'd1);
    end
    return n;
  endfunction

endpackage

// File: rtl/gshare_branch_predictor.sv
// Gshare predictor: 0-cycle combinational lookup, PHT/GHR trained one edge after feedback; always ready, no backpressure.
// Define BRANCH_PRED_STATS_EN to add saturating lookup/mispredict counters.
module gshare_branch_predictor
  import mips_core_pkg::*;
#(
  parameter int INDEX_BITS = 8,
  parameter int GHR_BITS   = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_req_valid,
  input  logic [31:0]         i_req_pc,
  output BranchOutcome        o_req_prediction,
  output logic [GHR_BITS-1:0] o_req_ghr,
  input  logic                i_fb_valid,
  input  logic [31:0]         i_fb_pc,
  input  logic [GHR_BITS-1:0] i_fb_ghr,
  input  BranchOutcome        i_fb_prediction,
  input  BranchOutcome        i_fb_outcome
`ifdef BRANCH_PRED_STATS_EN
  ,
  output logic [31:0]         o_stat_lookups,
  output logic [31:0]         o_stat_mispred
`endif
);

  localparam int ENTRIES = 1 << INDEX_BITS;

  if (GHR_BITS < 1 || GHR_BITS > INDEX_BITS) begin : g_bad_cfg
    $error("gshare_branch_predictor: GHR_BITS must be within 1..INDEX_BITS");
  end

  PhtState                 pht [ENTRIES];
  logic [GHR_BITS-1:0]     ghr;
  logic [GHR_BITS-1:0]     ghr_next;
  logic [INDEX_BITS-1:0]   req_idx;
  logic [INDEX_BITS-1:0]   fb_idx;

  assign req_idx = i_req_pc[INDEX_BITS+1:2] ^ INDEX_BITS'(ghr);
  // Training indexes with the snapshot the lookup used, not today's GHR.
  assign fb_idx  = i_fb_pc[INDEX_BITS+1:2] ^ INDEX_BITS'(i_fb_ghr);

  assign o_req_prediction = (i_req_valid && pht[req_idx][1]) ? TAKEN : NOT_TAKEN;
  assign o_req_ghr        = ghr;

  if (GHR_BITS == 1) begin : g_ghr1
    assign ghr_next = i_fb_outcome;
  end else begin : g_ghrn
    assign ghr_next = {i_fb_ghr[GHR_BITS-2:0], i_fb_outcome};
  end

  // History is rebuilt from the snapshot, so a mispredicted path repairs itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) pht[i] <= WEAK_NT;
      ghr <= '0;
    end else if (i_fb_valid) begin
      pht[fb_idx] <= pht_next(pht[fb_idx], i_fb_outcome);
      ghr         <= ghr_next;
    end
  end

`ifdef BRANCH_PRED_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_stat_lookups <= '0;
      o_stat_mispred <= '0;
    end else begin
      if (i_req_valid && o_stat_lookups != 32'hFFFF_FFFF)
        o_stat_lookups <= o_stat_lookups + 32'd1;
      if (i_fb_valid && i_fb_prediction != i_fb_outcome && o_stat_mispred != 32'hFFFF_FFFF)
        o_stat_mispred <= o_stat_mispred + 32'd1;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{i_req_pc[31:INDEX_BITS+2], i_req_pc[1:0],
                         i_fb_pc[31:INDEX_BITS+2], i_fb_pc[1:0]};
`else
  logic unused_bits;
  assign unused_bits = ^{i_req_pc[31:INDEX_BITS+2], i_req_pc[1:0],
                         i_fb_pc[31:INDEX_BITS+2], i_fb_pc[1:0], i_fb_prediction};
`endif

endmodule

// File: tb/tb_gshare_branch_predictor.sv
// Directed-vector bench for gshare_branch_predictor with a queue scoreboard and negedge monitor.
// Stats counters are checked when BRANCH_PRED_STATS_EN is defined.
module tb_gshare_branch_predictor;
  import mips_core_pkg::*;

  typedef struct {
    BranchOutcome pred;
    logic [7:0]   ghr;
    string        name;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_valid;
  logic [31:0]  req_pc;
  BranchOutcome req_prediction;
  logic [7:0]   req_ghr;
  logic         fb_valid;
  logic [31:0]  fb_pc;
  logic [7:0]   fb_ghr;
  BranchOutcome fb_prediction;
  BranchOutcome fb_outcome;
`ifdef BRANCH_PRED_STATS_EN
  logic [31:0]  stat_lookups;
  logic [31:0]  stat_mispred;
`endif

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  gshare_branch_predictor #(.INDEX_BITS(8), .GHR_BITS(8)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_req_valid      (req_valid),
    .i_req_pc         (req_pc),
    .o_req_prediction (req_prediction),
    .o_req_ghr        (req_ghr),
    .i_fb_valid       (fb_valid),
    .i_fb_pc          (fb_pc),
    .i_fb_ghr         (fb_ghr),
    .i_fb_prediction  (fb_prediction),
    .i_fb_outcome     (fb_outcome)
`ifdef BRANCH_PRED_STATS_EN
    ,
    .o_stat_lookups   (stat_lookups),
    .o_stat_mispred   (stat_mispred)
`endif
  );

  // Monitor: every cycle the DUT presents a valid lookup, pop and compare.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && req_valid === 1'b1) begin
      exp_t e;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_lookup: got pred=%0d ghr=%02h, nothing expected", req_prediction, req_ghr);
      end else begin
        e = exp_q.pop_front();
        if (req_prediction !== e.pred || req_ghr !== e.ghr) begin
          n_errors++;
          $display("FAIL %s: got pred=%0d ghr=%02h, expected pred=%0d ghr=%02h",
                   e.name, req_prediction, req_ghr, e.pred, e.ghr);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    req_valid     = 1'b0;
    req_pc        = 'x;
    fb_valid      = 1'b0;
    fb_pc         = 'x;
    fb_ghr        = 'x;
    fb_prediction = NOT_TAKEN;
    fb_outcome    = NOT_TAKEN;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic set_req(input logic [31:0] pc, input BranchOutcome p, input logic [7:0] g, input string name);
    exp_t e;
    req_valid = 1'b1;
    req_pc    = pc;
    e.pred = p;
    e.ghr  = g;
    e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic set_fb(input logic [31:0] pc, input logic [7:0] g, input BranchOutcome pr, input BranchOutcome o);
    fb_valid      = 1'b1;
    fb_pc         = pc;
    fb_ghr        = g;
    fb_prediction = pr;
    fb_outcome    = o;
  endtask

  task automatic lookup(input logic [31:0] pc, input BranchOutcome p, input logic [7:0] g, input string name);
    set_req(pc, p, g, name);
    tick();
  endtask

  task automatic train(input logic [31:0] pc, input logic [7:0] g, input BranchOutcome o);
    set_fb(pc, g, o, o);
    tick();
  endtask

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    lookup(32'h0040_0010, NOT_TAKEN, 8'h00, "reset_state");
`ifdef BRANCH_PRED_STATS_EN
    check32("reset_stat_mispred", stat_mispred, 32'd0);
`endif

    // Entry 0x08 via pc 0x20 with GHR=0, or pc 0x24 with GHR=1.
    train(32'h0040_0020, 8'h00, TAKEN);
    lookup(32'h0040_0024, TAKEN, 8'h01, "sat_t1_weak_t");
    train(32'h0040_0020, 8'h00, TAKEN);
    lookup(32'h0040_0024, TAKEN, 8'h01, "sat_t2_strong_t");
    train(32'h0040_0020, 8'h00, TAKEN);
    lookup(32'h0040_0024, TAKEN, 8'h01, "sat_t3_hold_11");
    train(32'h0040_0020, 8'h00, NOT_TAKEN);
    lookup(32'h0040_0020, TAKEN, 8'h00, "sat_n1_weak_t");
    train(32'h0040_0020, 8'h00, NOT_TAKEN);
    lookup(32'h0040_0020, NOT_TAKEN, 8'h00, "sat_n2_weak_nt");
    train(32'h0040_0020, 8'h00, NOT_TAKEN);
    lookup(32'h0040_0020, NOT_TAKEN, 8'h00, "sat_n3_strong_nt");
    train(32'h0040_0020, 8'h00, NOT_TAKEN);
    lookup(32'h0040_0020, NOT_TAKEN, 8'h00, "sat_n4_hold_00");
    train(32'h0040_0020, 8'h00, TAKEN);
    lookup(32'h0040_0024, NOT_TAKEN, 8'h01, "sat_up_from_00");
    train(32'h0040_0020, 8'h00, TAKEN);
    lookup(32'h0040_0024, TAKEN, 8'h01, "sat_up_to_10");

    // History T,T,N rebuilt from chained snapshots.
    train(32'h0040_0100, 8'h00, TAKEN);
    train(32'h0040_0100, 8'h01, TAKEN);
    train(32'h0040_0100, 8'h03, NOT_TAKEN);
    lookup(32'h0040_0200, NOT_TAKEN, 8'h06, "history_ttn");

    // Snapshot indexing while the live GHR is 0xA0.
    train(32'h0040_0300, 8'h50, NOT_TAKEN);
    lookup(32'h0040_0000, NOT_TAKEN, 8'hA0, "ghr_a0_setup");
    train(32'h0040_0040, 8'h05, TAKEN);
    lookup(32'h0040_0078, TAKEN, 8'h0B, "snap_idx_15_trained");
    lookup(32'h0040_02EC, NOT_TAKEN, 8'h0B, "snap_idx_b0_untouched");
    lookup(32'h0040_006C, NOT_TAKEN, 8'h0B, "snap_idx_10_untouched");

    // Same-cycle lookup and training of WEAK_NT entry 0x33.
    set_req(32'h0040_00E0, NOT_TAKEN, 8'h0B, "hazard_pre_update");
    set_fb(32'h0040_00E0, 8'h0B, NOT_TAKEN, TAKEN);
    tick();
    lookup(32'h0040_0090, TAKEN, 8'h17, "hazard_post_update");

    // X on inputs while valids are low must not disturb state.
    req_pc = 'x; fb_pc = 'x; fb_ghr = 'x;
    tick();
    lookup(32'h0040_0090, TAKEN, 8'h17, "x_inputs_idle");

    // Mid-run reset with a feedback in flight across the edge.
    set_fb(32'h0040_0020, 8'h00, TAKEN, TAKEN);
    #2 rst_n = 1'b0;
    @(posedge clk);
    #1 idle_inputs();
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    lookup(32'h0040_0010, NOT_TAKEN, 8'h00, "midrun_reset_pc10");
    lookup(32'h0040_0020, NOT_TAKEN, 8'h00, "midrun_reset_entry08");
    lookup(32'h0040_0090, NOT_TAKEN, 8'h00, "midrun_reset_entry24");

`ifdef BRANCH_PRED_STATS_EN
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    check32("stats_cleared", stat_lookups, 32'd0);
    for (int i = 0; i < 10; i++)
      lookup(32'h0040_0400 + 32'(i * 4), NOT_TAKEN, 8'h00, "stats_lookup");
    set_fb(32'h0040_0500, 8'h00, NOT_TAKEN, NOT_TAKEN); tick();
    set_fb(32'h0040_0504, 8'h00, NOT_TAKEN, NOT_TAKEN); tick();
    set_fb(32'h0040_0508, 8'h00, NOT_TAKEN, TAKEN);     tick();
    set_fb(32'h0040_050C, 8'h00, TAKEN, TAKEN);         tick();
    check32("stat_lookups", stat_lookups, 32'd10);
    check32("stat_mispred", stat_mispred, 32'd1);
`endif

    repeat (2) @(posedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: %0d expected lookups never observed, expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
